// File: rtl/disk_sector_fifo_pkg.sv
// Shared constants, entry layout and tag helper for the disk sector FIFO.
package disk_sector_fifo_pkg;

  // Default geometry: two full sectors of 256 words.
  localparam int DEFAULT_DEPTH_LOG2   = 9;
  localparam int DEFAULT_SECTOR_WORDS = 256;

  // Word layout held in storage: {tag, data}.
  localparam int DATA_W       = 16;
  localparam int FIFO_TAG_BIT = 16;
  localparam int ENTRY_W      = DATA_W + 1;

  // Sector-fill state of the write side, kept for readability of the top.
  typedef enum logic [1:0] {
    SECT_IDLE    = 2'd0,
    SECT_PARTIAL = 2'd1
  } sect_fill_t;

  // A word ends a sector when the producer marks it, or when it is the last
  // word that fits in a full sector.
  function automatic logic sector_tag(input logic wr_last,
                                      input int unsigned wr_word,
                                      input int unsigned sector_words);
    return wr_last || (wr_word == (sector_words - 1));
  endfunction

endpackage

// File: rtl/disk_sector_fifo_ram.sv
// Dual-port storage for the sector FIFO: synchronous write, asynchronous read
// so the head word falls through to the output without a read cycle.
module disk_sector_fifo_ram
  import disk_sector_fifo_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_DEPTH_LOG2
) (
  input  logic               qclk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [ENTRY_W-1:0] wr_entry,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [ENTRY_W-1:0] rd_entry
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Store the incoming {tag,data} word at the write pointer.
  always_ff @(posedge qclk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_entry;
    end
  end

  // Head word is presented combinationally at the read pointer.
  assign rd_entry = mem[rd_addr];

endmodule

// File: rtl/disk_sector_fifo.sv
// First-word-fall-through sector buffer between the Q-bus DMA engine and the
// disk micro-controller. Tracks sector framing with a per-word end tag and
// reports how many complete sectors are held.
module disk_sector_fifo
  import disk_sector_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2   = DEFAULT_DEPTH_LOG2,
  parameter int SECTOR_WORDS = DEFAULT_SECTOR_WORDS
) (
  input  logic                  qclk,
  input  logic                  init_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [15:0]           wr_data,
  input  logic                  wr_last,
  output logic                  full,
  input  logic                  rd_en,
  output logic [15:0]           rd_data,
  output logic                  rd_last,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic [DEPTH_LOG2:0]   sectors_rdy,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE        = (DEPTH_LOG2 + 1)'(1);

  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2-1:0] wr_word_reg;
  logic [DEPTH_LOG2:0]   level_reg;
  logic [DEPTH_LOG2:0]   sectors_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  sect_fill_t            fill_reg;

  logic                  wr_accept;
  logic                  rd_accept;
  logic                  wr_tag;
  logic                  rd_tag;
  logic [ENTRY_W-1:0]    head_entry;
  logic [ENTRY_W-1:0]    wr_entry;

  // Full/empty decode straight from the occupancy count.
  assign full  = (level_reg == LEVEL_FULL);
  assign empty = (level_reg == '0);

  // A push is taken when there is room, or when a pop frees a slot in the
  // same cycle; a pop needs at least one word held.
  assign wr_accept = wr_en && (!full || rd_en);
  assign rd_accept = rd_en && !empty;

  // Close the sector on an explicit marker or on the last word of a full one.
  assign wr_tag   = sector_tag(wr_last, int'(wr_word_reg), SECTOR_WORDS);
  assign wr_entry = {wr_tag, wr_data};

  disk_sector_fifo_ram #(
    .ADDR_W(DEPTH_LOG2)
  ) u_ram (
    .qclk    (qclk),
    .wr_en   (wr_accept && !clear),
    .wr_addr (wr_ptr_reg),
    .wr_entry(wr_entry),
    .rd_addr (rd_ptr_reg),
    .rd_entry(head_entry)
  );

  assign rd_tag  = head_entry[FIFO_TAG_BIT];
  assign rd_data = head_entry[DATA_W-1:0];
  assign rd_last = rd_tag;

  assign level       = level_reg;
  assign sectors_rdy = sectors_reg;
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;

  // Write and read pointers; both wrap naturally modulo the depth.
  always_ff @(posedge qclk or negedge init_n) begin
    if (!init_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_accept) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Occupancy: unchanged on push+pop, otherwise step by one.
  always_ff @(posedge qclk or negedge init_n) begin
    if (!init_n) begin
      level_reg <= '0;
    end else if (clear) begin
      level_reg <= '0;
    end else begin
      case ({wr_accept, rd_accept})
        2'b10:   level_reg <= level_reg + ONE;
        2'b01:   level_reg <= level_reg - ONE;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Position within the sector being written; restarts after a tagged word.
  always_ff @(posedge qclk or negedge init_n) begin
    if (!init_n) begin
      wr_word_reg <= '0;
      fill_reg    <= SECT_IDLE;
    end else if (clear) begin
      wr_word_reg <= '0;
      fill_reg    <= SECT_IDLE;
    end else if (wr_accept) begin
      if (wr_tag) begin
        wr_word_reg <= '0;
        fill_reg    <= SECT_IDLE;
      end else begin
        wr_word_reg <= wr_word_reg + 1'b1;
        fill_reg    <= SECT_PARTIAL;
      end
    end
  end

  // Complete sectors held: a tagged push adds one, a tagged pop removes one.
  always_ff @(posedge qclk or negedge init_n) begin
    if (!init_n) begin
      sectors_reg <= '0;
    end else if (clear) begin
      sectors_reg <= '0;
    end else begin
      case ({wr_accept && wr_tag, rd_accept && rd_tag})
        2'b10:   sectors_reg <= sectors_reg + ONE;
        2'b01:   sectors_reg <= sectors_reg - ONE;
        default: sectors_reg <= sectors_reg;
      endcase
    end
  end

  // Sticky error flags for dropped pushes and pops from an empty buffer.
  always_ff @(posedge qclk or negedge init_n) begin
    if (!init_n) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (clear) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_en && full && !rd_en) overflow_reg  <= 1'b1;
      if (rd_en && empty)          underflow_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_disk_sector_fifo.sv
// Self-checking bench for disk_sector_fifo using a queue scoreboard of
// expected {tag,data} words plus a small model of counters and flags.
module tb_disk_sector_fifo;

  localparam int DL2   = 9;
  localparam int DEPTH = 512;
  localparam int SW    = 256;

  logic              qclk = 1'b0;
  logic              init_n;
  logic              clear;
  logic              wr_en;
  logic [15:0]       wr_data;
  logic              wr_last;
  logic              full;
  logic              rd_en;
  logic [15:0]       rd_data;
  logic              rd_last;
  logic              empty;
  logic [DL2:0]      level;
  logic [DL2:0]      sectors_rdy;
  logic              overflow;
  logic              underflow;

  always #5 qclk = ~qclk;

  disk_sector_fifo #(
    .DEPTH_LOG2  (DL2),
    .SECTOR_WORDS(SW)
  ) dut (
    .qclk       (qclk),
    .init_n     (init_n),
    .clear      (clear),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .full       (full),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .empty      (empty),
    .level      (level),
    .sectors_rdy(sectors_rdy),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  logic [16:0] sb[$];
  int          m_wr_word;
  int          m_sect;
  logic        m_ovf;
  logic        m_udf;
  int          checks;
  int          failures;

  task automatic model_reset();
    sb.delete();
    m_wr_word = 0;
    m_sect    = 0;
    m_ovf     = 1'b0;
    m_udf     = 1'b0;
  endtask

  // One clock of stimulus, entered and left on a falling edge. When a pop
  // is taken the observed head word and the scoreboard word are returned.
  task automatic step(input logic we, input logic [15:0] wd, input logic wl,
                      input logic re, output logic popped,
                      output logic [16:0] obs, output logic [16:0] exp);
    logic do_push;
    logic tag;
    int   sz;
    sz      = sb.size();
    popped  = re && (sz > 0);
    do_push = we && ((sz < DEPTH) || re);
    obs     = {rd_last, rd_data};
    exp     = popped ? sb[0] : 17'h0;
    wr_en   = we;
    wr_data = wd;
    wr_last = wl;
    rd_en   = re;
    @(posedge qclk);
    #1;
    if (popped) begin
      void'(sb.pop_front());
      if (exp[16]) m_sect--;
    end
    if (do_push) begin
      tag = wl || (m_wr_word == SW - 1);
      sb.push_back({tag, wd});
      m_wr_word = tag ? 0 : m_wr_word + 1;
      if (tag) m_sect++;
    end
    if (we && !do_push) m_ovf = 1'b1;
    if (re && sz == 0)  m_udf = 1'b1;
    wr_en   = 1'b0;
    wr_last = 1'b0;
    rd_en   = 1'b0;
    @(negedge qclk);
    $display("txn we=%0b wd=%h wl=%0b re=%0b pop=%0b obs=%h level=%0d sect=%0d",
             we, wd, wl, re, popped, obs, level, sectors_rdy);
  endtask

  task automatic test_reset();
    init_n = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_data = '0; wr_last = 1'b0; rd_en = 1'b0;
    model_reset();
    repeat (2) @(negedge qclk);
    checks++;
    if (level !== 10'd0 || empty !== 1'b1 || full !== 1'b0 || sectors_rdy !== 10'd0 ||
        overflow !== 1'b0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state level=%0d empty=%0b full=%0b sect=%0d ovf=%0b udf=%0b expected 0/1/0/0/0/0",
               level, empty, full, sectors_rdy, overflow, underflow);
    end
    init_n = 1'b1;
    @(negedge qclk);
  endtask

  task automatic test_full_sector();
    logic p; logic [16:0] o, e;
    for (int i = 0; i < SW; i++) begin
      step(1'b1, 16'(i), 1'b0, 1'b0, p, o, e);
      if (i == SW - 2) begin
        checks++;
        if (sectors_rdy !== 10'd0) begin
          failures++; $display("FAIL sect_before_last got=%0d expected=0", sectors_rdy);
        end
      end
    end
    checks++;
    if (sectors_rdy !== 10'(m_sect) || level !== 10'(sb.size())) begin
      failures++;
      $display("FAIL sector_done sect=%0d level=%0d expected %0d/%0d", sectors_rdy, level, m_sect, sb.size());
    end
    for (int i = 0; i < SW; i++) begin
      step(1'b0, 16'h0, 1'b0, 1'b1, p, o, e);
      checks++;
      if (!p || o !== e) begin
        failures++; $display("FAIL full_sector_pop i=%0d got=%h expected=%h", i, o, e);
      end
    end
    checks++;
    if (empty !== 1'b1 || sectors_rdy !== 10'd0) begin
      failures++; $display("FAIL drained empty=%0b sect=%0d expected 1/0", empty, sectors_rdy);
    end
  endtask

  task automatic test_short_sector();
    logic p; logic [16:0] o, e;
    for (int i = 0; i < 10; i++) step(1'b1, 16'h1000 + 16'(i), (i == 9), 1'b0, p, o, e);
    checks++;
    if (sectors_rdy !== 10'd1) begin
      failures++; $display("FAIL short_sector_count got=%0d expected=1", sectors_rdy);
    end
    for (int i = 0; i < SW; i++) step(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0, p, o, e);
    checks++;
    if (sectors_rdy !== 10'd2 || level !== 10'd266) begin
      failures++; $display("FAIL after_resync sect=%0d level=%0d expected 2/266", sectors_rdy, level);
    end
    for (int i = 0; i < 10 + SW; i++) begin
      step(1'b0, 16'h0, 1'b0, 1'b1, p, o, e);
      checks++;
      if (!p || o !== e) begin
        failures++; $display("FAIL short_sector_pop i=%0d got=%h expected=%h", i, o, e);
      end
    end
  endtask

  task automatic test_full_wrap();
    logic p; logic [16:0] o, e;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b0, p, o, e);
    checks++;
    if (full !== 1'b1 || level !== 10'd512 || overflow !== 1'b0) begin
      failures++; $display("FAIL at_full full=%0b level=%0d ovf=%0b expected 1/512/0", full, level, overflow);
    end
    step(1'b1, 16'hDEAD, 1'b0, 1'b0, p, o, e);
    checks++;
    if (overflow !== 1'b1 || level !== 10'd512 || sectors_rdy !== 10'(m_sect)) begin
      failures++; $display("FAIL overflow ovf=%0b level=%0d sect=%0d expected 1/512/%0d",
                           overflow, level, sectors_rdy, m_sect);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'h4000 + 16'(i), 1'b0, 1'b1, p, o, e);
      checks++;
      if (!p || o !== e || level !== 10'd512) begin
        failures++; $display("FAIL pushpop_full i=%0d got=%h expected=%h level=%0d", i, o, e, level);
      end
    end
    while (sb.size() > 0) begin
      step(1'b0, 16'h0, 1'b0, 1'b1, p, o, e);
      checks++;
      if (!p || o !== e) begin
        failures++; $display("FAIL wrap_pop got=%h expected=%h", o, e);
      end
    end
    checks++;
    if (empty !== 1'b1 || sectors_rdy !== 10'(m_sect)) begin
      failures++; $display("FAIL wrap_drained empty=%0b sect=%0d expected 1/%0d", empty, sectors_rdy, m_sect);
    end
  endtask

  task automatic test_underflow();
    logic p; logic [16:0] o, e;
    step(1'b0, 16'h0, 1'b0, 1'b1, p, o, e);
    checks++;
    if (underflow !== 1'b1 || level !== 10'd0 || empty !== 1'b1) begin
      failures++; $display("FAIL underflow udf=%0b level=%0d empty=%0b expected 1/0/1", underflow, level, empty);
    end
    step(1'b1, 16'h5A5A, 1'b0, 1'b1, p, o, e);
    checks++;
    if (level !== 10'd1 || p !== 1'b0) begin
      failures++; $display("FAIL pushpop_empty level=%0d popped=%0b expected 1/0", level, p);
    end
    step(1'b0, 16'h0, 1'b0, 1'b1, p, o, e);
    checks++;
    if (!p || o !== e || empty !== 1'b1) begin
      failures++; $display("FAIL pushpop_empty_pop got=%h expected=%h empty=%0b", o, e, empty);
    end
  endtask

  task automatic test_clear();
    logic p; logic [16:0] o, e;
    for (int i = 0; i < 100; i++) step(1'b1, 16'h6000 + 16'(i), 1'b0, 1'b0, p, o, e);
    wr_en = 1'b1; wr_data = 16'hBEEF; clear = 1'b1;
    @(posedge qclk);
    #1;
    wr_en = 1'b0; clear = 1'b0;
    model_reset();
    @(negedge qclk);
    checks++;
    if (empty !== 1'b1 || level !== 10'd0 || overflow !== 1'b0 || underflow !== 1'b0 ||
        sectors_rdy !== 10'd0) begin
      failures++; $display("FAIL clear empty=%0b level=%0d ovf=%0b udf=%0b sect=%0d expected 1/0/0/0/0",
                           empty, level, overflow, underflow, sectors_rdy);
    end
    for (int i = 0; i < SW; i++) step(1'b1, 16'h7000 + 16'(i), 1'b0, 1'b0, p, o, e);
    for (int i = 0; i < SW; i++) begin
      step(1'b0, 16'h0, 1'b0, 1'b1, p, o, e);
      checks++;
      if (!p || o !== e) begin
        failures++; $display("FAIL post_clear_pop i=%0d got=%h expected=%h", i, o, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic p; logic [16:0] o, e;
    for (int i = 0; i < 12; i++) step(1'b1, 16'h8000 + 16'(i), (i == 4), 1'b0, p, o, e);
    @(posedge qclk);
    #2;
    init_n = 1'b0;
    #1;
    checks++;
    if (level !== 10'd0 || empty !== 1'b1 || full !== 1'b0 || sectors_rdy !== 10'd0) begin
      failures++; $display("FAIL async_reset level=%0d empty=%0b full=%0b sect=%0d expected 0/1/0/0",
                           level, empty, full, sectors_rdy);
    end
    model_reset();
    @(negedge qclk);
    init_n = 1'b1;
    @(negedge qclk);
    for (int i = 0; i < SW; i++) step(1'b1, 16'h9000 + 16'(i), 1'b0, 1'b0, p, o, e);
    checks++;
    if (sectors_rdy !== 10'd1) begin
      failures++; $display("FAIL reset_discard sect=%0d expected=1", sectors_rdy);
    end
    for (int i = 0; i < SW; i++) begin
      step(1'b0, 16'h0, 1'b0, 1'b1, p, o, e);
      checks++;
      if (!p || o !== e) begin
        failures++; $display("FAIL post_reset_pop i=%0d got=%h expected=%h", i, o, e);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_full_sector();
    test_short_sector();
    test_full_wrap();
    test_underflow();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
